fpmad_issue_arbiter: RTL and testbench

//  Shares one pipelined fpmad unit between NUM_REQ requesters (warp lanes/schedulers).

---
 rtl/fpmad_pkg.sv | 26 ++
 rtl/fpmad_issue_arbiter_if.sv | 46 ++++
 rtl/fpmad_rr_arbiter.sv | 42 ++++
 rtl/fpmad_issue_arbiter.sv | 148 ++++++++++++++
 tb/tb_fpmad_issue_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fpmad_pkg.sv
// ============================================================================
// Package     : fpmad_pkg
// Description : Types and constants shared by the fpmad unit and its issue
//               arbiter: the float_t operand type, the fpmad pipeline
//               latency and the default requester-id type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpmad_pkg;

    // IEEE-754 single-precision value, carried as raw bits.
    typedef logic [31:0] float_t;

    // Cycles from fpmad sampling its operands to its result being valid.
    localparam int FPMAD_LATENCY = 4;

    // Default number of requesters that share one fpmad.
    localparam int FPMAD_NUM_REQ = 4;

    // Requester id for the default configuration.
    typedef logic [$clog2(FPMAD_NUM_REQ)-1:0] req_id_t;

endpackage

`default_nettype wire

// File: rtl/fpmad_issue_arbiter_if.sv
// ============================================================================
// Interface   : fpmad_issue_arbiter_if
// Description : Bundles the requester-side handshake (requests, grants and
//               result strobes) and the fpmad-side operand/result bus.
//               master = requesters + fpmad, slave = the issue arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpmad_issue_arbiter_if
    import fpmad_pkg::*;
#(
    parameter int NUM_REQ = FPMAD_NUM_REQ
);
    // Requester side
    logic                      issue_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    float_t [NUM_REQ-1:0]      req_a;
    float_t [NUM_REQ-1:0]      req_b;
    float_t [NUM_REQ-1:0]      req_c;
    logic [NUM_REQ-1:0]        resp_valid;
    float_t                    resp_data;

    // fpmad side
    logic                      fpmad_valid;
    float_t                    fpmad_a;
    float_t                    fpmad_b;
    float_t                    fpmad_c;
    float_t                    fpmad_res;

    modport master (
        output issue_en, req_valid, req_a, req_b, req_c, fpmad_res,
        input  req_ready, resp_valid, resp_data,
               fpmad_valid, fpmad_a, fpmad_b, fpmad_c
    );

    modport slave (
        input  issue_en, req_valid, req_a, req_b, req_c, fpmad_res,
        output req_ready, resp_valid, resp_data,
               fpmad_valid, fpmad_a, fpmad_b, fpmad_c
    );

endinterface

`default_nettype wire

// File: rtl/fpmad_rr_arbiter.sv
// ============================================================================
// Module      : fpmad_rr_arbiter
// Description : Combinational round-robin picker. Scans requesters from ptr
//               upward (mod NUM_REQ) and grants the first valid one. The
//               pointer register lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmad_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req_valid,
    input  wire logic               issue_en,
    input  wire logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0]      grant,
    output logic [ID_W-1:0]         grant_id,
    output logic                    grant_any
);

    // First valid requester at or after ptr wins; nothing when disabled.
    always_comb begin
        int          idx;
        logic [ID_W-1:0] sel;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            sel = ID_W'(idx);
            if (!grant_any && issue_en && req_valid[sel]) begin
                grant[sel] = 1'b1;
                grant_id   = sel;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpmad_issue_arbiter.sv
// ============================================================================
// Module      : fpmad_issue_arbiter
// Description : Shares one pipelined fpmad between NUM_REQ requesters. One
//               round-robin grant per cycle; operands are registered into
//               fpmad, and a tag pipe matched to the fpmad depth steers each
//               result back to the requester that issued it.
//               Optional feature macro: FPMAD_ISSUE_ARB_PERF_EN adds
//               saturating 16-bit per-requester grant counters (perf_grants).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmad_issue_arbiter
    import fpmad_pkg::*;
#(
    parameter int NUM_REQ = FPMAD_NUM_REQ,
    parameter int LATENCY = FPMAD_LATENCY
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fpmad_issue_arbiter_if.slave   bus
`ifdef FPMAD_ISSUE_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][15:0] perf_grants
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic               arb_en;

    logic               issue_valid;
    float_t             issue_a;
    float_t             issue_b;
    float_t             issue_c;

    logic [LATENCY:0]   tag_valid;
    logic [ID_W-1:0]    tag_id [LATENCY+1];

    logic [NUM_REQ-1:0] resp_valid;
    float_t             resp_data;

    // No grants while reset is asserted, so nobody believes it was accepted.
    assign arb_en = bus.issue_en & rst;

    fpmad_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_valid (bus.req_valid),
        .issue_en  (arb_en),
        .ptr       (ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign bus.req_ready   = grant;
    assign bus.fpmad_valid = issue_valid;
    assign bus.fpmad_a     = issue_a;
    assign bus.fpmad_b     = issue_b;
    assign bus.fpmad_c     = issue_c;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_data   = resp_data;

    // Round-robin pointer: move just past the winner, hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + 1'b1;
            end
        end
    end

    // Issue register: capture the winner's operands; hold them when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_valid <= 1'b0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_c     <= '0;
        end else begin
            issue_valid <= grant_any;
            if (grant_any) begin
                issue_a <= bus.req_a[grant_id];
                issue_b <= bus.req_b[grant_id];
                issue_c <= bus.req_c[grant_id];
            end
        end
    end

    // Tag pipe: free-running, since fpmad has fixed latency and no stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[LATENCY-1:0], grant_any};
            tag_id[0] <= grant_id;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Response register: the tag exiting the pipe lines up with fpmad_res.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            if (tag_valid[LATENCY]) begin
                resp_valid <= NUM_REQ'(1) << tag_id[LATENCY];
                resp_data  <= bus.fpmad_res;
            end else begin
                resp_valid <= '0;
            end
        end
    end

`ifdef FPMAD_ISSUE_ARB_PERF_EN
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
            // Saturating count of accepted requests for requester i.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    perf_grants[i] <= '0;
                end else if (grant[i] && (perf_grants[i] != 16'hFFFF)) begin
                    perf_grants[i] <= perf_grants[i] + 16'd1;
                end
            end
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpmad_issue_arbiter.sv
// ============================================================================
// Module      : tb_fpmad_issue_arbiter
// Description : Directed self-checking bench for fpmad_issue_arbiter with a
//               stub fpmad whose result is fpmad_a delayed LATENCY cycles.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpmad_issue_arbiter;
    import fpmad_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fpmad_issue_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef FPMAD_ISSUE_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] perf_grants;
`endif

    fpmad_issue_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FPMAD_ISSUE_ARB_PERF_EN
        ,
        .perf_grants (perf_grants)
`endif
    );

    // Stub fpmad: result is operand a, LATENCY cycles later.
    float_t stub_pipe [LATENCY];
    always @(posedge clk) begin
        stub_pipe[0] <= bus.fpmad_a;
        for (int k = 1; k < LATENCY; k++) stub_pipe[k] <= stub_pipe[k-1];
    end
    assign bus.fpmad_res = stub_pipe[LATENCY-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.issue_en  = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i] = 32'h1000_0000 + i;
            bus.req_b[i] = 32'h2000_0000 + i;
            bus.req_c[i] = 32'h3000_0000 + i;
        end

        // ---- 1. reset held 3 cycles with every requester valid
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
            chk("rst_fpmad_valid", 64'(bus.fpmad_valid), 64'h0);
            chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        end
        chk("rst_fpmad_a", 64'(bus.fpmad_a), 64'h0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'h0);
        bus.req_valid = '0;
        rst = 1'b1;

        // ---- 2. single request from requester 0
        cyc();
        bus.req_valid = 4'b0001;
        bus.req_a[0]  = 32'h3F80_0000;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h1);
        cyc();
        bus.req_valid = '0;
        chk("single_fpmad_valid", 64'(bus.fpmad_valid), 64'h1);
        chk("single_fpmad_a", 64'(bus.fpmad_a), 64'h3F80_0000);
        chk("single_fpmad_b", 64'(bus.fpmad_b), 64'h2000_0000);
        for (int k = 2; k < 6; k++) begin
            cyc();
            chk("single_early_resp", 64'(bus.resp_valid), 64'h0);
            if (k == 2) begin
                chk("single_idle_fpmad_valid", 64'(bus.fpmad_valid), 64'h0);
                chk("single_hold_fpmad_a", 64'(bus.fpmad_a), 64'h3F80_0000);
            end
        end
        cyc();
        chk("single_resp_valid", 64'(bus.resp_valid), 64'h1);
        chk("single_resp_data", 64'(bus.resp_data), 64'h3F80_0000);
        cyc();
        chk("single_resp_once", 64'(bus.resp_valid), 64'h0);

        // Pointer is now 1; a lone grant to requester 3 wraps it to 0.
        bus.req_valid = 4'b1000;
        bus.req_a[3]  = 32'h4040_0000;
        #1;
        chk("wrap_ready", 64'(bus.req_ready), 64'h8);
        cyc();
        bus.req_valid = '0;
        for (int k = 1; k < 6; k++) cyc();
        chk("wrap_resp_valid", 64'(bus.resp_valid), 64'h8);
        chk("wrap_resp_data", 64'(bus.resp_data), 64'h4040_0000);

        // ---- 3. all four valid for 8 cycles: 0,1,2,3,0,1,2,3
        cyc();
        for (int i = 0; i < NUM_REQ; i++) bus.req_a[i] = 32'h4000_0000 + i;
        for (int k = 0; k < 14; k++) begin
            bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            if (k >= 1 && k <= 8) chk("rr_fpmad_a", 64'(bus.fpmad_a), 64'(32'h4000_0000 + ((k - 1) % 4)));
            if (k >= 6) begin
                chk("rr_resp_valid", 64'(bus.resp_valid), 64'(4'b0001 << ((k - 6) % 4)));
                chk("rr_resp_data", 64'(bus.resp_data), 64'(32'h4000_0000 + ((k - 6) % 4)));
            end
            cyc();
        end
        chk("rr_drained", 64'(bus.resp_valid), 64'h0);

        // ---- 4. back-to-back requester 0 for 6 cycles, then issue_en=0
        for (int k = 0; k < 16; k++) begin
            bus.req_valid = 4'b0001;
            bus.issue_en  = (k < 6);
            bus.req_a[0]  = 32'h3F00_0000 + k;
            #1;
            chk("b2b_ready", 64'(bus.req_ready), (k < 6) ? 64'h1 : 64'h0);
            if (k == 7) chk("b2b_drain_fpmad_valid", 64'(bus.fpmad_valid), 64'h0);
            if (k >= 6 && k < 12) begin
                chk("b2b_resp_valid", 64'(bus.resp_valid), 64'h1);
                chk("b2b_resp_data", 64'(bus.resp_data), 64'(32'h3F00_0000 + (k - 6)));
            end else begin
                chk("b2b_no_resp", 64'(bus.resp_valid), 64'h0);
            end
            cyc();
        end
        bus.req_valid = '0;
        bus.issue_en  = 1'b1;

        // ---- 5. one-cycle reset with three ops in flight
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'b0001;
            bus.req_a[0]  = 32'h1111_0000 + k;
            cyc();
        end
        bus.req_valid = '0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("midrst_fpmad_valid", 64'(bus.fpmad_valid), 64'h0);
        for (int k = 0; k < 7; k++) begin
            chk("midrst_no_resp", 64'(bus.resp_valid), 64'h0);
            cyc();
        end
        bus.req_valid = 4'b0100;
        bus.req_a[2]  = 32'hCAFE_BABE;
        #1;
        chk("post_rst_ready", 64'(bus.req_ready), 64'h4);
        cyc();
        bus.req_valid = '0;
        for (int k = 1; k < 6; k++) begin
            chk("post_rst_early", 64'(bus.resp_valid), 64'h0);
            cyc();
        end
        chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'h4);
        chk("post_rst_resp_data", 64'(bus.resp_data), 64'hCAFE_BABE);

`ifdef FPMAD_ISSUE_ARB_PERF_EN
        // ---- 6. 70000 grants to requester 2 saturate its counter
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("perf_clear", 64'(perf_grants), 64'h0);
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 70000; k++) cyc();
        bus.req_valid = '0;
        cyc();
        chk("perf_sat_req2", 64'(perf_grants[2]), 64'hFFFF);
        chk("perf_req0", 64'(perf_grants[0]), 64'h0);
        chk("perf_req1", 64'(perf_grants[1]), 64'h0);
        chk("perf_req3", 64'(perf_grants[3]), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
